// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine sequencer and its phase timer:
// phase encoding, default phase durations and the actuator-to-phase decoder.
package wash_pkg;

   typedef enum logic [2:0] {
      NONE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      DRAIN = 3'd3,
      SPIN  = 3'd4
   } phase_t;

   localparam int DEF_CLK_PER_SEC = 50_000_000;
   localparam int DEF_FILL_SEC    = 60;
   localparam int DEF_WASH_SEC    = 600;
   localparam int DEF_RINSE_SEC   = 300;
   localparam int DEF_DRAIN_SEC   = 90;
   localparam int DEF_SPIN_SEC    = 240;
   localparam int DEF_SEC_W       = 10;

   // First match wins: fill beats drain beats spin beats wash.
   function automatic phase_t decode_phase(input logic water_fill,
                                           input logic agitator,
                                           input logic motor,
                                           input logic pump,
                                           input logic speed);
      phase_t ph;
      if (water_fill)             ph = FILL;
      else if (pump)              ph = DRAIN;
      else if (motor && speed)    ph = SPIN;
      else if (motor && agitator) ph = WASH;
      else                        ph = NONE;
      return ph;
   endfunction

endpackage

// File: rtl/wash_cycle_timer_sec_prescaler.sv
// Clock-to-seconds prescaler: emits a one-cycle tick every CLK_PER_SEC enabled
// clocks; holds its count while disabled and clears on clr or rst.
module sec_prescaler
   import wash_pkg::*;
#(
   parameter int CLK_PER_SEC = DEF_CLK_PER_SEC
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic             at_last;

   assign at_last = (pre_q == PRE_LAST);
   // A clear in the same cycle suppresses the tick so restart always wins.
   assign tick    = en & at_last & ~clr;

   always_comb begin
      pre_d = pre_q;
      if (clr) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = at_last ? '0 : pre_q + PRE_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/wash_cycle_timer.sv
// Phase timer for the washing-machine sequencer: decodes the active phase from
// the actuator outputs, counts seconds and returns registered phase-done levels.
module wash_cycle_timer
   import wash_pkg::*;
#(
   parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
   parameter int FILL_SEC    = DEF_FILL_SEC,
   parameter int WASH_SEC    = DEF_WASH_SEC,
   parameter int RINSE_SEC   = DEF_RINSE_SEC,
   parameter int DRAIN_SEC   = DEF_DRAIN_SEC,
   parameter int SPIN_SEC    = DEF_SPIN_SEC,
   parameter int SEC_W       = DEF_SEC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic             water_fill,
   input  logic             agitator,
   input  logic             motor,
   input  logic             pump,
   input  logic             speed,
   output logic             tfill,
   output logic             twash,
   output logic             trinse,
   output logic             tdrain,
   output logic             tspin,
   output logic [SEC_W-1:0] remaining
);

   localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

   phase_t           phase;
   logic [SEC_W-1:0] target;
   logic             done_cur;
   logic             cnt_en;
   logic             tick;
   logic             last_sec;

   logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
   logic [SEC_W-1:0] remaining_q, remaining_d;
   logic             tfill_q, tfill_d;
   logic             twash_q, twash_d;
   logic             trinse_q, trinse_d;
   logic             tdrain_q, tdrain_d;
   logic             tspin_q, tspin_d;
   logic             rinse_q, rinse_d;

   always_comb begin
      phase    = decode_phase(water_fill, agitator, motor, pump, speed);
      target   = '0;
      done_cur = 1'b0;
      case (phase)
         FILL:  begin target = SEC_W'(FILL_SEC);  done_cur = tfill_q;  end
         WASH:  begin
            target   = rinse_q ? SEC_W'(RINSE_SEC) : SEC_W'(WASH_SEC);
            done_cur = twash_q;
         end
         DRAIN: begin target = SEC_W'(DRAIN_SEC); done_cur = tdrain_q; end
         SPIN:  begin target = SEC_W'(SPIN_SEC);  done_cur = tspin_q;  end
         default: begin target = '0; done_cur = 1'b0; end
      endcase
   end

   assign cnt_en   = (phase != NONE) & ~done_cur;
   assign last_sec = tick & (sec_cnt_q == (target - SEC_ONE));

   sec_prescaler #(
      .CLK_PER_SEC (CLK_PER_SEC)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (restart),
      .en   (cnt_en),
      .tick (tick)
   );

   always_comb begin
      sec_cnt_d = sec_cnt_q;
      tfill_d   = tfill_q;
      twash_d   = twash_q;
      trinse_d  = trinse_q;
      tdrain_d  = tdrain_q;
      tspin_d   = tspin_q;
      rinse_d   = rinse_q;
      if (restart) begin
         sec_cnt_d = '0;
         tfill_d   = 1'b0;
         twash_d   = 1'b0;
         trinse_d  = 1'b0;
         tdrain_d  = 1'b0;
         tspin_d   = 1'b0;
      end else begin
         if (tick && (sec_cnt_q < target)) begin
            sec_cnt_d = sec_cnt_q + SEC_ONE;
         end
         // Each done level holds only while its own phase stays decoded.
         tfill_d  = (phase == FILL)  & (tfill_q  | last_sec);
         twash_d  = (phase == WASH)  & (twash_q  | last_sec);
         trinse_d = (phase == WASH)  & (trinse_q | (last_sec & rinse_q));
         tdrain_d = (phase == DRAIN) & (tdrain_q | last_sec);
         tspin_d  = (phase == SPIN)  & (tspin_q  | last_sec);
         if (last_sec && (phase == DRAIN) && !rinse_q) begin
            rinse_d = 1'b1;
         end
         if (last_sec && (phase == SPIN)) begin
            rinse_d = 1'b0;
         end
      end
      // The display keeps its last value through a door-open hold.
      remaining_d = (phase == NONE) ? remaining_q : (target - sec_cnt_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sec_cnt_q   <= '0;
         remaining_q <= '0;
         tfill_q     <= 1'b0;
         twash_q     <= 1'b0;
         trinse_q    <= 1'b0;
         tdrain_q    <= 1'b0;
         tspin_q     <= 1'b0;
         rinse_q     <= 1'b0;
      end else begin
         sec_cnt_q   <= sec_cnt_d;
         remaining_q <= remaining_d;
         tfill_q     <= tfill_d;
         twash_q     <= twash_d;
         trinse_q    <= trinse_d;
         tdrain_q    <= tdrain_d;
         tspin_q     <= tspin_d;
         rinse_q     <= rinse_d;
      end
   end

   assign tfill     = tfill_q;
   assign twash     = twash_q;
   assign trinse    = trinse_q;
   assign tdrain    = tdrain_q;
   assign tspin     = tspin_q;
   assign remaining = remaining_q;

endmodule
